myproject: RTL and testbench

- Streaming image-feature extractor at the back end of the crop/Gaussian path; consumes one cropped ROWS×COLS frame of signed fixed-point pixels over an AXI-Stream-style input.
- Produces five scalar Gaussian-style features, each on its own single-beat output stream: peak amplitude, peak row, peak column, scaled intensity sum, positive-pixel count.
- Sequenced by an ap_ctrl_hs block-level handshake (ap_start/ap_done/ap_idle/ap_ready).

---
 rtl/myproject_pkg.sv | 30 +++
 rtl/myproject_out_reg.sv | 24 ++
 rtl/myproject.sv | 175 +++++++++++++++++
 tb/tb_myproject.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/myproject_pkg.sv
// Shared parameters, FSM state type and sum saturation helper for the feature extractor.
package myproject_pkg;
    localparam int FP_TOTAL  = 16;
    localparam int ROWS      = 48;
    localparam int COLS      = 48;
    localparam int SUM_SHIFT = 11;
    localparam int NOUT      = 5;

    localparam int NPIX  = ROWS * COLS;
    localparam int IDX_W = $clog2(NPIX);
    localparam int SUM_W = FP_TOTAL + IDX_W;
    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = $clog2(COLS);
    localparam int CNT_W = $clog2(NPIX + 1);

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

    typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;

    function automatic logic [FP_TOTAL-1:0] saturate(input logic signed [SUM_W-1:0] v);
        logic signed [SUM_W-1:0] hi;
        logic signed [SUM_W-1:0] lo;
        hi = SUM_W'((1 << (FP_TOTAL - 1)) - 1);
        lo = -hi - SUM_W'(1);
        if (v > hi)      return {1'b0, {(FP_TOTAL-1){1'b1}}};
        else if (v < lo) return {1'b1, {(FP_TOTAL-1){1'b0}}};
        else             return v[FP_TOTAL-1:0];
    endfunction
endpackage

// File: rtl/myproject_out_reg.sv
// Single-beat valid/ready holding register for one scalar result stream.
module myproject_out_reg
    import myproject_pkg::*;
(
    input  logic                ap_clk,
    input  logic                ap_rst_n,
    input  logic                load,
    input  logic [FP_TOTAL-1:0] din,
    input  logic                ready,
    output logic                valid,
    output logic [FP_TOTAL-1:0] data
);
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= din;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/myproject.sv
// Streaming peak/sum/count feature extractor over one ROWS x COLS frame with ap_ctrl_hs control.
// Define MYPROJECT_SUM_SAT_EN to saturate the shifted sum output instead of wrapping it.
module myproject
    import myproject_pkg::*;
(
    input  logic                ap_clk,
    input  logic                ap_rst_n,
    input  logic                ap_start,
    output logic                ap_done,
    output logic                ap_idle,
    output logic                ap_ready,
    input  logic [FP_TOTAL-1:0] conv2d_input_V_data_0_V_TDATA,
    input  logic                conv2d_input_V_data_0_V_TVALID,
    output logic                conv2d_input_V_data_0_V_TREADY,
    output logic [FP_TOTAL-1:0] layer15_out_V_data_0_V_TDATA,
    output logic                layer15_out_V_data_0_V_TVALID,
    input  logic                layer15_out_V_data_0_V_TREADY,
    output logic [FP_TOTAL-1:0] layer15_out_V_data_1_V_TDATA,
    output logic                layer15_out_V_data_1_V_TVALID,
    input  logic                layer15_out_V_data_1_V_TREADY,
    output logic [FP_TOTAL-1:0] layer15_out_V_data_2_V_TDATA,
    output logic                layer15_out_V_data_2_V_TVALID,
    input  logic                layer15_out_V_data_2_V_TREADY,
    output logic [FP_TOTAL-1:0] layer15_out_V_data_3_V_TDATA,
    output logic                layer15_out_V_data_3_V_TVALID,
    input  logic                layer15_out_V_data_3_V_TREADY,
    output logic [FP_TOTAL-1:0] layer15_out_V_data_4_V_TDATA,
    output logic                layer15_out_V_data_4_V_TVALID,
    input  logic                layer15_out_V_data_4_V_TREADY
);
    state_t state, state_nxt;
    logic   done_nxt, ready_nxt;

    logic signed [FP_TOTAL-1:0] pix;
    logic                       accept, last_acc, first_pix, pix_pos;
    logic [ROW_W-1:0]           row, peak_row, peak_row_nxt;
    logic [COL_W-1:0]           col, peak_col, peak_col_nxt;
    logic signed [FP_TOTAL-1:0] max_val, max_nxt;
    logic signed [SUM_W-1:0]    sum, sum_nxt, sum_shr;
    logic [CNT_W-1:0]           cnt, cnt_nxt;

    logic [NOUT-1:0][FP_TOTAL-1:0] res_din, res_data;
    logic [NOUT-1:0]               res_valid, res_ready;

    assign pix       = signed'(conv2d_input_V_data_0_V_TDATA);
    assign accept    = conv2d_input_V_data_0_V_TVALID && conv2d_input_V_data_0_V_TREADY;
    assign last_acc  = accept && (row == ROW_LAST) && (col == COL_LAST);
    assign first_pix = (row == '0) && (col == '0);
    assign pix_pos   = !pix[FP_TOTAL-1] && (pix != '0);

    assign conv2d_input_V_data_0_V_TREADY = (state == RUN);
    assign ap_idle = (state == IDLE);

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        ready_nxt = 1'b0;
        case (state)
            IDLE: if (ap_start) state_nxt = RUN;
            RUN: begin
                if (last_acc) begin
                    state_nxt = OUT;
                    ready_nxt = 1'b1;
                end
            end
            OUT: begin
                // Leave once every stream is either already drained or handshaking now.
                if ((res_valid & ~res_ready) == '0) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state    <= IDLE;
            ap_done  <= 1'b0;
            ap_ready <= 1'b0;
        end else begin
            state    <= state_nxt;
            ap_done  <= done_nxt;
            ap_ready <= ready_nxt;
        end
    end

    // Strict compare keeps the first occurrence of a tied peak.
    always_comb begin
        max_nxt      = max_val;
        peak_row_nxt = peak_row;
        peak_col_nxt = peak_col;
        if (first_pix || (pix > max_val)) begin
            max_nxt      = pix;
            peak_row_nxt = row;
            peak_col_nxt = col;
        end
        sum_nxt = sum + {{(SUM_W-FP_TOTAL){pix[FP_TOTAL-1]}}, pix};
        cnt_nxt = cnt + (pix_pos ? CNT_W'(1) : CNT_W'(0));
        sum_shr = sum_nxt >>> SUM_SHIFT;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            row      <= '0;
            col      <= '0;
            peak_row <= '0;
            peak_col <= '0;
            max_val  <= '0;
            sum      <= '0;
            cnt      <= '0;
        end else if (state == IDLE && ap_start) begin
            row      <= '0;
            col      <= '0;
            peak_row <= '0;
            peak_col <= '0;
            max_val  <= '0;
            sum      <= '0;
            cnt      <= '0;
        end else if (accept) begin
            max_val  <= max_nxt;
            peak_row <= peak_row_nxt;
            peak_col <= peak_col_nxt;
            sum      <= sum_nxt;
            cnt      <= cnt_nxt;
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    // Results are captured from the post-update values on the last pixel's cycle.
    always_comb begin
        res_din[0] = max_nxt;
        res_din[1] = {{(FP_TOTAL-ROW_W){1'b0}}, peak_row_nxt};
        res_din[2] = {{(FP_TOTAL-COL_W){1'b0}}, peak_col_nxt};
`ifdef MYPROJECT_SUM_SAT_EN
        res_din[3] = saturate(sum_shr);
`else
        res_din[3] = sum_shr[FP_TOTAL-1:0];
`endif
        res_din[4] = {{(FP_TOTAL-CNT_W){1'b0}}, cnt_nxt};
    end

    assign res_ready = {layer15_out_V_data_4_V_TREADY, layer15_out_V_data_3_V_TREADY,
                        layer15_out_V_data_2_V_TREADY, layer15_out_V_data_1_V_TREADY,
                        layer15_out_V_data_0_V_TREADY};

    for (genvar g = 0; g < NOUT; g++) begin : g_out
        myproject_out_reg u_out (
            .ap_clk   (ap_clk),
            .ap_rst_n (ap_rst_n),
            .load     (last_acc),
            .din      (res_din[g]),
            .ready    (res_ready[g]),
            .valid    (res_valid[g]),
            .data     (res_data[g])
        );
    end

    assign layer15_out_V_data_0_V_TDATA  = res_data[0];
    assign layer15_out_V_data_1_V_TDATA  = res_data[1];
    assign layer15_out_V_data_2_V_TDATA  = res_data[2];
    assign layer15_out_V_data_3_V_TDATA  = res_data[3];
    assign layer15_out_V_data_4_V_TDATA  = res_data[4];
    assign layer15_out_V_data_0_V_TVALID = res_valid[0];
    assign layer15_out_V_data_1_V_TVALID = res_valid[1];
    assign layer15_out_V_data_2_V_TVALID = res_valid[2];
    assign layer15_out_V_data_3_V_TVALID = res_valid[3];
    assign layer15_out_V_data_4_V_TVALID = res_valid[4];
endmodule

// File: tb/tb_myproject.sv
// Directed self-checking bench for the myproject feature extractor.
module tb_myproject;
    import myproject_pkg::*;

    logic ap_clk = 1'b0;
    logic ap_rst_n = 1'b0;
    logic ap_start = 1'b0;
    logic ap_done, ap_idle, ap_ready;
    logic [FP_TOTAL-1:0] in_data = '0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [NOUT-1:0][FP_TOTAL-1:0] odata;
    logic [NOUT-1:0] ovalid;
    logic [NOUT-1:0] oready = '0;

    int n_chk = 0;
    int n_fail = 0;

    always #5 ap_clk = ~ap_clk;

    myproject dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .ap_start (ap_start),
        .ap_done  (ap_done),
        .ap_idle  (ap_idle),
        .ap_ready (ap_ready),
        .conv2d_input_V_data_0_V_TDATA  (in_data),
        .conv2d_input_V_data_0_V_TVALID (in_valid),
        .conv2d_input_V_data_0_V_TREADY (in_ready),
        .layer15_out_V_data_0_V_TDATA   (odata[0]),
        .layer15_out_V_data_0_V_TVALID  (ovalid[0]),
        .layer15_out_V_data_0_V_TREADY  (oready[0]),
        .layer15_out_V_data_1_V_TDATA   (odata[1]),
        .layer15_out_V_data_1_V_TVALID  (ovalid[1]),
        .layer15_out_V_data_1_V_TREADY  (oready[1]),
        .layer15_out_V_data_2_V_TDATA   (odata[2]),
        .layer15_out_V_data_2_V_TVALID  (ovalid[2]),
        .layer15_out_V_data_2_V_TREADY  (oready[2]),
        .layer15_out_V_data_3_V_TDATA   (odata[3]),
        .layer15_out_V_data_3_V_TVALID  (ovalid[3]),
        .layer15_out_V_data_3_V_TREADY  (oready[3]),
        .layer15_out_V_data_4_V_TDATA   (odata[4]),
        .layer15_out_V_data_4_V_TVALID  (ovalid[4]),
        .layer15_out_V_data_4_V_TREADY  (oready[4])
    );

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [FP_TOTAL-1:0] pix_of(input int mode, input int p);
        case (mode)
            1: return (p == 10*COLS + 20) ? 16'd100 : 16'd0;
            2: return 16'd1000;
            3: return 16'h7FFF;
            4: return 16'hFFFB;
            default: return 16'd0;
        endcase
    endfunction

    // Starts a frame and feeds pixels until stop_at have been accepted.
    task automatic run_frame(input string nm, input int mode, input bit rnd, input int stop_at);
        int p = 0;
        int guard = 0;
        int rdy = 0;
        bit acc;
        ap_start = 1'b1;
        @(posedge ap_clk); #1;
        ap_start = 1'b0;
        check({nm, "_idle_low"}, int'(ap_idle), 0);
        while (p < stop_at && guard < 4*NPIX) begin
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = pix_of(mode, p);
            if (rnd) ap_start = 1'($urandom_range(0, 1));
            acc = in_valid && in_ready;
            @(posedge ap_clk); #1;
            guard++;
            if (acc) p++;
            if (ap_ready) rdy++;
        end
        in_valid = 1'b0;
        ap_start = 1'b0;
        check({nm, "_accepted"}, p, stop_at);
        if (stop_at == NPIX) begin
            check({nm, "_ready_pulses"}, rdy, 1);
            check({nm, "_ready_now"}, int'(ap_ready), 1);
            check({nm, "_in_ready_off"}, int'(in_ready), 0);
            check({nm, "_ovalid"}, int'(ovalid), 31);
        end
    endtask

    task automatic check_data(input string nm, input int e0, input int e1, input int e2,
                              input int e3, input int e4);
        check({nm, "_out0"}, int'(odata[0]), e0 & 32'hFFFF);
        check({nm, "_out1"}, int'(odata[1]), e1 & 32'hFFFF);
        check({nm, "_out2"}, int'(odata[2]), e2 & 32'hFFFF);
        check({nm, "_out3"}, int'(odata[3]), e3 & 32'hFFFF);
        check({nm, "_out4"}, int'(odata[4]), e4 & 32'hFFFF);
    endtask

    // All sinks ready: every stream drains on one edge and ap_done follows.
    task automatic finish_out(input string nm, input int e0, input int e1, input int e2,
                              input int e3, input int e4);
        check_data(nm, e0, e1, e2, e3, e4);
        check({nm, "_done_early"}, int'(ap_done), 0);
        oready = '1;
        @(posedge ap_clk); #1;
        oready = '0;
        check({nm, "_done"}, int'(ap_done), 1);
        check({nm, "_idle_back"}, int'(ap_idle), 1);
        check({nm, "_ovalid_clr"}, int'(ovalid), 0);
        @(posedge ap_clk); #1;
        check({nm, "_done_pulse"}, int'(ap_done), 0);
    endtask

    task automatic hold_release(input string nm, input int e0, input int e1, input int e2,
                                input int e3, input int e4);
        int bad = 0;
        int order [NOUT] = '{2, 0, 4, 1, 3};
        logic [NOUT-1:0] left = '1;
        check_data(nm, e0, e1, e2, e3, e4);
        for (int i = 0; i < 1000; i++) begin
            @(posedge ap_clk); #1;
            if (ovalid !== 5'h1F || ap_done !== 1'b0 || odata[0] !== 16'(e0) ||
                odata[1] !== 16'(e1) || odata[2] !== 16'(e2) || odata[3] !== 16'(e3) ||
                odata[4] !== 16'(e4)) bad++;
        end
        check({nm, "_hold_bad"}, bad, 0);
        for (int i = 0; i < NOUT; i++) begin
            oready[order[i]] = 1'b1;
            @(posedge ap_clk); #1;
            oready[order[i]] = 1'b0;
            left[order[i]] = 1'b0;
            check({nm, "_rel_valid"}, int'(ovalid), int'(left));
            check({nm, "_rel_done"}, int'(ap_done), (i == NOUT-1) ? 1 : 0);
        end
        @(posedge ap_clk); #1;
        check({nm, "_done_pulse"}, int'(ap_done), 0);
        check({nm, "_idle_back"}, int'(ap_idle), 1);
    endtask

    initial begin
        #12;
        check("rst_idle", int'(ap_idle), 1);
        check("rst_done", int'(ap_done), 0);
        check("rst_ready", int'(ap_ready), 0);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_ovalid", int'(ovalid), 0);
        check("rst_odata", int'(|odata), 0);
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1;

        // Input traffic in IDLE must be refused.
        in_valid = 1'b1;
        in_data  = 16'hBEEF;
        repeat (5) @(posedge ap_clk);
        #1;
        check("idle_in_ready", int'(in_ready), 0);
        check("idle_stays", int'(ap_idle), 1);
        in_valid = 1'b0;

        run_frame("t1", 0, 1'b0, NPIX);
        finish_out("t1", 0, 0, 0, 0, 0);

        run_frame("t2", 1, 1'b0, NPIX);
        finish_out("t2", 100, 10, 20, 0, 1);

        run_frame("t3", 2, 1'b0, NPIX);
        finish_out("t3", 1000, 0, 0, 1125, 2304);

        run_frame("t4a", 3, 1'b0, NPIX);
`ifdef MYPROJECT_SUM_SAT_EN
        finish_out("t4a", 32767, 0, 0, 32767, 2304);
`else
        finish_out("t4a", 32767, 0, 0, 36862, 2304);
`endif

        run_frame("t4b", 4, 1'b0, NPIX);
        finish_out("t4b", -5, 0, 0, -6, 0);

        run_frame("t5", 1, 1'b1, NPIX);
        hold_release("t5", 100, 10, 20, 0, 1);

        run_frame("t6_part", 2, 1'b0, 500);
        ap_rst_n = 1'b0;
        #2;
        check("t6_rst_idle", int'(ap_idle), 1);
        check("t6_rst_in_ready", int'(in_ready), 0);
        check("t6_rst_ovalid", int'(ovalid), 0);
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;
        run_frame("t6", 1, 1'b0, NPIX);
        finish_out("t6", 100, 10, 20, 0, 1);
        for (int r = 0; r < 5; r++) begin
            run_frame($sformatf("t6_run%0d", r), 1, 1'b0, NPIX);
            finish_out($sformatf("t6_run%0d", r), 100, 10, 20, 0, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
